// File: rtl/stream_mux_nx1_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux_nx1_pkg
//  Brief    : Shared types and constants for the N:1 streaming multiplexer
//             (arbiter state encoding and arbitration-mode selectors).
//  Revision : 1.0 - initial release
// ============================================================================
package stream_mux_nx1_pkg;

    // Arbiter FSM states: free arbitration vs. held mid-packet grant
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } mux_state_e;

    // Arbitration policy selectors for the MODE parameter
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

endpackage : stream_mux_nx1_pkg
`default_nettype wire

// File: rtl/stream_mux_nx1_if.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux_nx1_if
//  Brief    : Bundle of the N producer streams, the shared consumer stream
//             and the arbiter status outputs of the N:1 streaming mux.
//  Revision : 1.0 - initial release
// ============================================================================
interface stream_mux_nx1_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int IW = $clog2(N);

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_last;
    logic           out_ready;
    logic [IW-1:0]  grant_idx;
    logic           locked;

    // Mux side: consumes producer streams, drives the consumer stream
    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, grant_idx, locked
    );

    // Environment side: producers and consumer
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, grant_idx, locked
    );

endinterface : stream_mux_nx1_if
`default_nettype wire

// File: rtl/stream_mux_nx1_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational N-way arbiter. Fixed priority (lowest index) or
//             round-robin search starting at i_ptr with wrap at N.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import stream_mux_nx1_pkg::*;
#(
    parameter int N    = 4,
    parameter int MODE = MODE_FIXED
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    input  logic                 i_en,
    output logic [N-1:0]         o_gnt,
    output logic [$clog2(N)-1:0] o_idx
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] w_start;
    logic [IW:0]   w_cand;
    logic          w_found;

    // Fixed priority is simply a round-robin search that always starts at 0
    assign w_start = (MODE == MODE_RR) ? i_ptr : '0;

    // Search upward from w_start; the extra bit keeps ptr+k from overflowing
    // so the wrap happens at N even when N is not a power of two
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = {1'b0, w_start} + (IW+1)'(k);
            if (w_cand >= (IW+1)'(N)) begin
                w_cand = w_cand - (IW+1)'(N);
            end
            if (!w_found && i_req[w_cand[IW-1:0]]) begin
                w_found = 1'b1;
                o_idx   = w_cand[IW-1:0];
            end
        end
        if (i_en && w_found) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/stream_mux_nx1.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux_nx1
//  Brief    : N-input, W-bit valid/ready streaming multiplexer with fixed or
//             round-robin arbitration, optional packet locking on last, and
//             a registered output stage.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_mux_nx1
    import stream_mux_nx1_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MODE     = MODE_FIXED,
    parameter int LOCK_PKT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    stream_mux_nx1_if.slave bus
);
    localparam int IW = $clog2(N);

    localparam logic [0:0] c_ST_IDLE   = 1'(ST_IDLE);
    localparam logic [0:0] c_ST_LOCKED = 1'(ST_LOCKED);

    logic [0:0]    r_state;
    logic [IW-1:0] r_lock_ch;
    logic [IW-1:0] r_ptr;
    logic [W-1:0]  r_out_data;
    logic          r_out_valid;
    logic          r_out_last;
    logic [IW-1:0] r_grant_idx;

    logic [W-1:0]  w_ch_data [N];
    logic [N-1:0]  w_arb_gnt;
    logic [IW-1:0] w_arb_idx;
    logic [N-1:0]  w_sel;
    logic [IW-1:0] w_gnt_idx;
    logic [IW-1:0] w_ptr_next;
    logic [N-1:0]  w_in_ready;
    logic          w_load_en;
    logic          w_xfer;
    logic          w_beat_last;

    // Unpack the flat data bus into per-channel words
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign w_ch_data[gi] = bus.in_data[gi*W +: W];
    end

    // Output register can take a new beat when empty or being drained
    assign w_load_en = !r_out_valid || bus.out_ready;

    rr_arbiter #(
        .N    (N),
        .MODE (MODE)
    ) u_arb (
        .i_req (bus.in_valid),
        .i_ptr (r_ptr),
        .i_en  (r_state == c_ST_IDLE),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx)
    );

    // Current grant: the arbiter's pick when idle, the locked channel otherwise
    always_comb begin
        w_gnt_idx = w_arb_idx;
        w_sel     = w_arb_gnt;
        if (r_state == c_ST_LOCKED) begin
            w_gnt_idx = r_lock_ch;
            w_sel     = N'(1) << r_lock_ch;
        end
    end

    assign w_in_ready  = (rst_n && w_load_en) ? w_sel : '0;
    assign w_xfer      = |(bus.in_valid & w_in_ready);
    assign w_beat_last = bus.in_last[w_gnt_idx];
    assign w_ptr_next  = (w_gnt_idx == IW'(N-1)) ? '0 : w_gnt_idx + 1'b1;

    // Output stage: load on an accepted beat, drop valid when drained empty
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_grant_idx <= '0;
        end else if (w_load_en) begin
            r_out_valid <= w_xfer;
            if (w_xfer) begin
                r_out_data  <= w_ch_data[w_gnt_idx];
                r_out_last  <= w_beat_last;
                r_grant_idx <= w_gnt_idx;
            end
        end
    end

    // Lock FSM and round-robin pointer; the pointer moves only on release
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_lock_ch <= '0;
            r_ptr     <= '0;
        end else if (w_xfer) begin
            case (r_state)
                c_ST_IDLE: begin
                    if ((LOCK_PKT != 0) && !w_beat_last) begin
                        r_state   <= c_ST_LOCKED;
                        r_lock_ch <= w_gnt_idx;
                    end else begin
                        r_ptr <= w_ptr_next;
                    end
                end
                c_ST_LOCKED: begin
                    if (w_beat_last) begin
                        r_state <= c_ST_IDLE;
                        r_ptr   <= w_ptr_next;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.grant_idx = r_grant_idx;
    assign bus.locked    = (r_state == c_ST_LOCKED);

endmodule : stream_mux_nx1
`default_nettype wire

// File: tb/tb_stream_mux_nx1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_mux_nx1
//  Brief    : Directed self-checking bench for stream_mux_nx1. Three
//             instances: fixed priority with lock, round-robin without lock,
//             round-robin with lock.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_mux_nx1;

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    stream_mux_nx1_if #(.N(4), .W(8)) fp_if ();
    stream_mux_nx1_if #(.N(4), .W(8)) rr_if ();
    stream_mux_nx1_if #(.N(4), .W(8)) rl_if ();

    stream_mux_nx1 #(.N(4), .W(8), .MODE(0), .LOCK_PKT(1)) dut_fp (
        .clk (clk), .rst_n (rst_n), .bus (fp_if)
    );
    stream_mux_nx1 #(.N(4), .W(8), .MODE(1), .LOCK_PKT(0)) dut_rr (
        .clk (clk), .rst_n (rst_n), .bus (rr_if)
    );
    stream_mux_nx1 #(.N(4), .W(8), .MODE(1), .LOCK_PKT(1)) dut_rl (
        .clk (clk), .rst_n (rst_n), .bus (rl_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: sim time exceeded, got timeout exp finish");
        $fatal(1);
    end

    // Advance to just after the next rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        fp_if.in_data  = {8'h33, 8'h22, 8'h11, 8'h00};
        fp_if.in_last  = 4'hF;
        fp_if.in_valid = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (fp_if.in_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready: got %b exp 0000", fp_if.in_ready); end
        tests++; if (fp_if.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b exp 0", fp_if.out_valid); end
        tests++; if (fp_if.out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data: got %h exp 00", fp_if.out_data); end
        tests++; if (fp_if.grant_idx !== 2'd0) begin fails++; $display("FAIL reset_grant_idx: got %0d exp 0", fp_if.grant_idx); end
        tests++; if (fp_if.locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b exp 0", fp_if.locked); end
        rst_n = 1'b1;
        fp_if.in_valid = 4'b1010;
        #1;
        tests++; if (fp_if.in_ready !== 4'b0010) begin fails++; $display("FAIL release_in_ready: got %b exp 0010", fp_if.in_ready); end
        tick();
        tests++; if (fp_if.out_valid !== 1'b1) begin fails++; $display("FAIL release_out_valid: got %b exp 1", fp_if.out_valid); end
        tests++; if (fp_if.grant_idx !== 2'd1) begin fails++; $display("FAIL release_grant_idx: got %0d exp 1", fp_if.grant_idx); end
        tests++; if (fp_if.out_data !== 8'h11) begin fails++; $display("FAIL release_out_data: got %h exp 11", fp_if.out_data); end
        fp_if.in_valid = 4'b0000;
        tick();
        tests++; if (fp_if.out_valid !== 1'b0) begin fails++; $display("FAIL drain_out_valid: got %b exp 0", fp_if.out_valid); end
    endtask

    task automatic test_round_robin;
        logic [7:0] exp_seq [5];
        exp_seq = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        rr_if.in_data  = {8'h33, 8'h22, 8'h11, 8'h00};
        rr_if.in_last  = 4'hF;
        rr_if.in_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if ({rr_if.out_valid, rr_if.out_data} !== {1'b1, exp_seq[i]}) begin
                fails++;
                $display("FAIL rr_beat%0d: got valid=%b data=%h exp valid=1 data=%h", i, rr_if.out_valid, rr_if.out_data, exp_seq[i]);
            end
        end
        rr_if.in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_packet_lock;
        fp_if.in_data  = {8'h00, 8'hA0, 8'h00, 8'h55};
        fp_if.in_last  = 4'b0001;
        fp_if.in_valid = 4'b0100;
        #1;
        tests++; if (fp_if.in_ready !== 4'b0100) begin fails++; $display("FAIL lock_b0_ready: got %b exp 0100", fp_if.in_ready); end
        tick();
        tests++; if (fp_if.out_data !== 8'hA0 || fp_if.locked !== 1'b1) begin fails++; $display("FAIL lock_b0_out: got data=%h locked=%b exp data=a0 locked=1", fp_if.out_data, fp_if.locked); end
        fp_if.in_valid = 4'b0101;
        fp_if.in_data  = {8'h00, 8'hA1, 8'h00, 8'h55};
        #1;
        tests++; if (fp_if.in_ready !== 4'b0100) begin fails++; $display("FAIL lock_b1_ready: got %b exp 0100", fp_if.in_ready); end
        tick();
        tests++; if (fp_if.out_data !== 8'hA1 || fp_if.locked !== 1'b1) begin fails++; $display("FAIL lock_b1_out: got data=%h locked=%b exp data=a1 locked=1", fp_if.out_data, fp_if.locked); end
        fp_if.in_data  = {8'h00, 8'hA2, 8'h00, 8'h55};
        fp_if.in_last  = 4'b0101;
        #1;
        tests++; if (fp_if.in_ready !== 4'b0100) begin fails++; $display("FAIL lock_b2_ready: got %b exp 0100", fp_if.in_ready); end
        tick();
        tests++; if (fp_if.out_data !== 8'hA2 || fp_if.out_last !== 1'b1 || fp_if.locked !== 1'b0) begin fails++; $display("FAIL lock_b2_out: got data=%h last=%b locked=%b exp a2/1/0", fp_if.out_data, fp_if.out_last, fp_if.locked); end
        fp_if.in_valid = 4'b0001;
        #1;
        tests++; if (fp_if.in_ready !== 4'b0001) begin fails++; $display("FAIL lock_ch0_ready: got %b exp 0001", fp_if.in_ready); end
        tick();
        tests++; if (fp_if.out_data !== 8'h55 || fp_if.grant_idx !== 2'd0) begin fails++; $display("FAIL lock_ch0_out: got data=%h grant=%0d exp 55/0", fp_if.out_data, fp_if.grant_idx); end
        fp_if.in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure;
        fp_if.in_data  = {8'h00, 8'h00, 8'hB0, 8'h00};
        fp_if.in_last  = 4'b0010;
        fp_if.in_valid = 4'b0010;
        fp_if.out_ready = 1'b1;
        tick();
        tests++; if (fp_if.out_data !== 8'hB0) begin fails++; $display("FAIL bp_first: got %h exp b0", fp_if.out_data); end
        fp_if.in_data   = {8'h00, 8'h00, 8'hB1, 8'h00};
        fp_if.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++; if (fp_if.in_ready !== 4'b0000) begin fails++; $display("FAIL bp_stall_ready%0d: got %b exp 0000", i, fp_if.in_ready); end
            tick();
            tests++; if (fp_if.out_data !== 8'hB0 || fp_if.out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold%0d: got data=%h valid=%b exp b0/1", i, fp_if.out_data, fp_if.out_valid); end
        end
        fp_if.out_ready = 1'b1;
        #1;
        tests++; if (fp_if.in_ready !== 4'b0010) begin fails++; $display("FAIL bp_resume_ready: got %b exp 0010", fp_if.in_ready); end
        tick();
        tests++; if (fp_if.out_data !== 8'hB1) begin fails++; $display("FAIL bp_second: got %h exp b1", fp_if.out_data); end
        fp_if.in_data = {8'h00, 8'h00, 8'hB2, 8'h00};
        tick();
        tests++; if (fp_if.out_data !== 8'hB2) begin fails++; $display("FAIL bp_third: got %h exp b2", fp_if.out_data); end
        fp_if.in_valid = 4'b0000;
        tick();
        tests++; if (fp_if.out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty: got %b exp 0", fp_if.out_valid); end
    endtask

    task automatic test_bubble;
        fp_if.in_data  = {8'hD3, 8'h00, 8'hC0, 8'h00};
        fp_if.in_last  = 4'b1000;
        fp_if.in_valid = 4'b1010;
        #1;
        tests++; if (fp_if.in_ready !== 4'b0010) begin fails++; $display("FAIL bub_start_ready: got %b exp 0010", fp_if.in_ready); end
        tick();
        tests++; if (fp_if.out_data !== 8'hC0 || fp_if.locked !== 1'b1) begin fails++; $display("FAIL bub_b0: got data=%h locked=%b exp c0/1", fp_if.out_data, fp_if.locked); end
        fp_if.in_valid = 4'b1000;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++; if (fp_if.in_ready !== 4'b0010) begin fails++; $display("FAIL bub_hold_ready%0d: got %b exp 0010", i, fp_if.in_ready); end
            tick();
            tests++; if (fp_if.out_valid !== 1'b0 || fp_if.locked !== 1'b1) begin fails++; $display("FAIL bub_gap%0d: got valid=%b locked=%b exp 0/1", i, fp_if.out_valid, fp_if.locked); end
        end
        fp_if.in_valid = 4'b1010;
        fp_if.in_data  = {8'hD3, 8'h00, 8'hC1, 8'h00};
        fp_if.in_last  = 4'b1010;
        tick();
        tests++; if (fp_if.out_data !== 8'hC1 || fp_if.out_last !== 1'b1 || fp_if.locked !== 1'b0 || fp_if.grant_idx !== 2'd1) begin fails++; $display("FAIL bub_last: got data=%h last=%b locked=%b grant=%0d exp c1/1/0/1", fp_if.out_data, fp_if.out_last, fp_if.locked, fp_if.grant_idx); end
        fp_if.in_valid = 4'b1000;
        #1;
        tests++; if (fp_if.in_ready !== 4'b1000) begin fails++; $display("FAIL bub_ch3_ready: got %b exp 1000", fp_if.in_ready); end
        tick();
        tests++; if (fp_if.out_data !== 8'hD3 || fp_if.grant_idx !== 2'd3) begin fails++; $display("FAIL bub_ch3_out: got data=%h grant=%0d exp d3/3", fp_if.out_data, fp_if.grant_idx); end
        fp_if.in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_packet;
        rl_if.in_data  = {8'h33, 8'h22, 8'h11, 8'h00};
        rl_if.in_last  = 4'b0100;
        rl_if.in_valid = 4'b0100;
        tick();
        tests++; if (rl_if.out_data !== 8'h22 || rl_if.grant_idx !== 2'd2) begin fails++; $display("FAIL rmp_single: got data=%h grant=%0d exp 22/2", rl_if.out_data, rl_if.grant_idx); end
        rl_if.in_last  = 4'b0000;
        rl_if.in_valid = 4'b1000;
        #1;
        tests++; if (rl_if.in_ready !== 4'b1000) begin fails++; $display("FAIL rmp_ch3_ready: got %b exp 1000", rl_if.in_ready); end
        tick();
        tests++; if (rl_if.out_data !== 8'h33 || rl_if.locked !== 1'b1) begin fails++; $display("FAIL rmp_locked: got data=%h locked=%b exp 33/1", rl_if.out_data, rl_if.locked); end
        rst_n = 1'b0;
        #1;
        tests++; if (rl_if.in_ready !== 4'b0000) begin fails++; $display("FAIL rmp_rst_ready: got %b exp 0000", rl_if.in_ready); end
        tick();
        tests++; if (rl_if.locked !== 1'b0 || rl_if.out_valid !== 1'b0 || rl_if.out_data !== 8'h00) begin fails++; $display("FAIL rmp_after_rst: got locked=%b valid=%b data=%h exp 0/0/00", rl_if.locked, rl_if.out_valid, rl_if.out_data); end
        rst_n = 1'b1;
        rl_if.in_last  = 4'hF;
        rl_if.in_valid = 4'hF;
        #1;
        tests++; if (rl_if.in_ready !== 4'b0001) begin fails++; $display("FAIL rmp_restart_ready: got %b exp 0001", rl_if.in_ready); end
        tick();
        tests++; if (rl_if.out_data !== 8'h00 || rl_if.grant_idx !== 2'd0) begin fails++; $display("FAIL rmp_restart_out: got data=%h grant=%0d exp 00/0", rl_if.out_data, rl_if.grant_idx); end
        rl_if.in_valid = 4'b0000;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        fp_if.in_data = '0; fp_if.in_valid = '0; fp_if.in_last = '0; fp_if.out_ready = 1'b1;
        rr_if.in_data = '0; rr_if.in_valid = '0; rr_if.in_last = '0; rr_if.out_ready = 1'b1;
        rl_if.in_data = '0; rl_if.in_valid = '0; rl_if.in_last = '0; rl_if.out_ready = 1'b1;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_bubble();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_stream_mux_nx1
`default_nettype wire

// File: doc/stream_mux_nx1.md
Name: stream_mux_nx1

Overview:
- Parametrised N-input, W-bit streaming multiplexer. It succeeds the single-bit 2:1 combinational select mux.
- Select is replaced by an internal arbiter (fixed-priority or round-robin) with valid/ready handshakes on every input and on the output.
- Optional packet locking via a last flag keeps a multi-beat packet contiguous.
- The output is registered. The block sits between several producer streams and one shared consumer, such as a UART TX or memory port.

Parameters:
- N, 4, number of input channels (2..16).
- W, 8, data width per channel.
- MODE, 0, arbitration policy: 0 = fixed priority (lowest index wins), 1 = round-robin.
- LOCK_PKT, 1, packet lock: 1 = grant is held from the first beat through the beat with last=1; 0 = arbitration happens on every beat.
- IW, $clog2(N), derived grant index width. This is a localparam, not overridable.

Ports:
- clk, input, 1, single clock; rising edge.
- rst_n, input, 1, synchronous active-low reset.
- in_data, input, N*W, channel i occupies bits [i*W +: W].
- in_valid, input, N, per-channel valid.
- in_last, input, N, per-channel end-of-packet flag.
- in_ready, output, N, per-channel ready (one-hot or zero).
- out_data, output, W, registered output data.
- out_valid, output, 1, output valid.
- out_last, output, 1, registered last flag of the current output beat.
- out_ready, input, 1, consumer ready.
- grant_idx, output, IW, index of the channel owning the current output beat.
- locked, output, 1, high while the arbiter holds a mid-packet lock.

Behaviour:
- Reset (rst_n=0 at a clk edge) forces:
  - out_valid=0, out_data=0, out_last=0, grant_idx=0, locked=0.
  - FSM to IDLE and RR pointer to 0.
  - in_ready is all-zero while rst_n=0.
- Reset mid-packet abandons the packet. No partial-packet recovery is attempted.
- Output register load condition: load_en = !out_valid | out_ready.
- Handshake rules:
  - in_ready[g] = load_en & (g is the current grant). All other in_ready bits are 0.
  - in_ready may depend combinationally on in_valid.
  - A beat transfers on in_valid[g] & in_ready[g]. On the next edge: out_data = that channel's data, out_last = in_last[g], grant_idx = g, out_valid = 1.
- Latency: exactly 1 cycle from input acceptance to out_valid.
- Throughput: 1 beat per cycle while out_ready=1.
- Output holding: out_valid stays 1 and out_data/out_last stay stable until out_ready=1. If out_ready=1 and no input transfers that cycle, out_valid goes to 0.
- FSM state IDLE:
  - Grant is selected combinationally from in_valid.
  - MODE=0: lowest-index asserted valid wins.
  - MODE=1: first asserted valid at or after the RR pointer wins, searching upward with wrap from N-1 to 0.
  - On a transfer with LOCK_PKT=1 and in_last[g]=0: go to LOCKED and latch g as lock_ch.
- FSM state LOCKED:
  - Grant is lock_ch regardless of other valids.
  - Return to IDLE on the transfer with in_last[lock_ch]=1.
  - locked=1 while in LOCKED.
- RR pointer update: set to (g+1) mod N when a grant is released. With LOCK_PKT=0 that means every transfer; with LOCK_PKT=1 it means the last beat of a packet.
- RR pointer is not updated when no transfer occurs. It is unused when MODE=0.
- Boundary conditions:
  - No valids in IDLE: in_ready=0 and state is unchanged.
  - Valid dropping while LOCKED (a bubble): lock is held and other channels stay stalled.
  - A single-beat packet (last=1 on the first beat) never enters LOCKED.
  - in_valid[g] rising in the same cycle a lock releases: the new grant is evaluated from the IDLE rules on the next cycle.
  - Pointer wrap: grant N-1 released gives pointer 0.
  - N not a power of two: wrap at N, never at 2^IW.

Decomposition:
- Shared package mux_pkg holds the state enum (IDLE, LOCKED) and a MODE_FIXED / MODE_RR constant pair.
- One natural sub-module: rr_arbiter (N, MODE). Inputs: request vector, pointer, enable. Outputs: one-hot grant and binary index. It is purely combinational.
- The top level holds the FSM, the pointer, and the output register.

Test Plan:
- Reset and idle: hold rst_n=0 for 3 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0. After release with N=4, MODE=0, in_valid=4'b1010 -> ch1 granted; next cycle out_valid=1, grant_idx=1.
- Round-robin fairness: MODE=1, LOCK_PKT=0, all four channels valid with constant data i*0x11, out_ready=1 -> output sequence 0x00, 0x11, 0x22, 0x33, 0x00, one beat per cycle.
- Packet lock: ch2 sends 3 beats (last on the 3rd) while ch0 stays valid -> ch0 in_ready=0 throughout; locked=1 for 2 cycles; ch0's beat appears immediately after ch2's last beat.
- Backpressure: out_ready=0 for 5 cycles after the first beat -> out_data stable, all in_ready=0. When out_ready=1 the next beat loads in the same cycle with no loss or duplication (scoreboard compare).
- Bubble in lock: ch1 packet with in_valid low for 2 cycles mid-packet while ch3 is valid -> grant stays on ch1 and ch3 waits.
- Reset mid-packet: assert rst_n=0 while LOCKED -> next cycle locked=0, out_valid=0, RR pointer 0. Subsequent arbitration starts from ch0.
